// File: rtl/ahblite_spi_master.sv
// AHB-lite slave SPI master: CPU writes a byte, hardware shifts it out in SPI mode 3 (MSB first) while capturing MISO.
// Latency: zero-wait-state bus; a transfer takes DATA_W*2*(DIV+1) HCLK cycles from the first SPI_CLK low to idle.
// Backpressure: none on the bus (HREADYOUT tied high); DATA/DIV writes issued while busy are dropped.
//
// Ports:
//   HCLK/HRESETn         system clock, async active-low reset
//   HSEL..HREADY         AHB-lite slave address/data phase inputs (HSIZE/HPROT ignored)
//   HREADYOUT/HRDATA/HRESP  slave response; always OKAY, never stalls
//   SPI_CS/SPI_CLK/SPI_MOSI/SPI_MISO  SPI pins; CS is purely software-driven
//   spi_irq              one-cycle pulse at end of transfer when interrupts are enabled
module ahblite_spi_master #(
  parameter int DIV_W  = 8,
  parameter int DATA_W = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        SPI_CS,
  output logic        SPI_CLK,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  output logic        spi_irq
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_DIV  = 2'd1;
  localparam logic [1:0] A_DATA = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t            state;
  logic              acc_q;
  logic              wr_q;
  logic [1:0]        addr_q;
  logic              ctrl_cs;
  logic              ctrl_ie;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  divcnt;
  logic [CNT_W-1:0]  bitcnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [DATA_W-1:0] rx_q;
  logic              done;

  logic              busy;
  logic              wr_en;
  logic              wr_ctrl;
  logic              wr_div;
  logic              wr_data;
  logic              wr_stat;
  logic              hi_entry;
  logic              finish;
  logic [DATA_W-1:0] rx_next;
  logic              unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign SPI_CS    = ctrl_cs;

  assign unused_ok = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA};

  // Address phase capture; the write is applied in the following data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_q  <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
    end else if (HREADY) begin
      acc_q  <= HSEL & HTRANS[1];
      wr_q   <= HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  assign busy    = (state != IDLE);
  assign wr_en   = acc_q & wr_q & HREADY;
  assign wr_ctrl = wr_en && (addr_q == A_CTRL);
  assign wr_div  = wr_en && (addr_q == A_DIV);
  assign wr_data = wr_en && (addr_q == A_DATA);
  assign wr_stat = wr_en && (addr_q == A_STAT);

  // divcnt is reloaded with DIV on every phase entry and DIV cannot change
  // while busy, so divcnt==DIV identifies the first cycle of a HIGH phase.
  assign hi_entry = (state == HIGH) && (divcnt == div_q);
  assign rx_next  = hi_entry ? {rx_sh[DATA_W-2:0], SPI_MISO} : rx_sh;
  assign finish   = (state == HIGH) && (divcnt == '0) && (bitcnt == '0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_cs <= 1'b1;
      ctrl_ie <= 1'b0;
      div_q   <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_cs <= HWDATA[0];
        ctrl_ie <= HWDATA[1];
      end
      if (wr_div && !busy) begin
        div_q <= HWDATA[DIV_W-1:0];
      end
    end
  end

  // A completing transfer beats a same-cycle write-1-to-clear.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      done <= 1'b0;
    end else if (finish) begin
      done <= 1'b1;
    end else if (wr_data && !busy) begin
      done <= 1'b0;
    end else if (wr_stat && HWDATA[1]) begin
      done <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_q     <= '0;
      bitcnt   <= '0;
      divcnt   <= '0;
      SPI_CLK  <= 1'b1;
      SPI_MOSI <= 1'b0;
      spi_irq  <= 1'b0;
    end else begin
      spi_irq <= 1'b0;
      rx_sh   <= rx_next;
      case (state)
        IDLE: begin
          SPI_CLK <= 1'b1;
          if (wr_data) begin
            tx_sh    <= HWDATA[DATA_W-1:0];
            bitcnt   <= CNT_W'(DATA_W - 1);
            divcnt   <= div_q;
            SPI_CLK  <= 1'b0;
            SPI_MOSI <= HWDATA[DATA_W-1];
            state    <= LOW;
          end
        end
        LOW: begin
          if (divcnt == '0) begin
            divcnt  <= div_q;
            SPI_CLK <= 1'b1;
            state   <= HIGH;
          end else begin
            divcnt <= divcnt - DIV_W'(1);
          end
        end
        HIGH: begin
          if (divcnt == '0) begin
            if (bitcnt == '0) begin
              // rx_next covers DIV=0, where the sample and the exit share a cycle.
              rx_q    <= rx_next;
              spi_irq <= ctrl_ie;
              state   <= IDLE;
            end else begin
              tx_sh    <= tx_sh << 1;
              SPI_MOSI <= tx_sh[DATA_W-2];
              bitcnt   <= bitcnt - CNT_W'(1);
              divcnt   <= div_q;
              SPI_CLK  <= 1'b0;
              state    <= LOW;
            end
          end else begin
            divcnt <= divcnt - DIV_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          SPI_CLK <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    case (addr_q)
      A_CTRL:  HRDATA[1:0] = {ctrl_ie, ctrl_cs};
      A_DIV:   HRDATA[DIV_W-1:0] = div_q;
      A_DATA:  HRDATA[DATA_W-1:0] = rx_q;
      default: HRDATA[1:0] = {done, busy};
    endcase
  end

endmodule

// File: tb/tb_ahblite_spi_master.sv
`timescale 1ns/1ps
module tb_ahblite_spi_master;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;
  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_DIV  = 32'h4;
  localparam logic [31:0] A_DATA = 32'h8;
  localparam logic [31:0] A_STAT = 32'hC;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        SPI_CS;
  logic        SPI_CLK;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic        spi_irq;

  logic        loop_en;
  logic        miso_lvl;

  int vectors     = 0;
  int miscompares = 0;

  bit          mosi_q[$];
  logic [7:0]  rx_q[$];

  assign SPI_MISO = loop_en ? SPI_MOSI : miso_lvl;

  always #5 HCLK = ~HCLK;

  ahblite_spi_master #(.DIV_W(DIV_W), .DATA_W(DATA_W)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .SPI_CS(SPI_CS),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .spi_irq(spi_irq)
  );

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  // Queue the expected serial bits / received byte, then kick the transfer.
  task automatic start_xfer(input logic [7:0] d, input logic [7:0] exp_rx, input bit watch);
    if (watch) begin
      for (int i = DATA_W - 1; i >= 0; i--) mosi_q.push_back(d[i]);
    end
    rx_q.push_back(exp_rx);
    ahb_write(A_DATA, {24'h0, d});
  endtask

  // Must be entered right after start_xfer returns: cycle 1 is the first LOW cycle.
  task automatic spi_watch(input int div, input int exp_irq, input string tag);
    int   lowrun = 0;
    int   highrun = 0;
    int   nrise = 0;
    int   last_rise = -1;
    int   irqs = 0;
    logic prev = 1'b1;
    bit   b;
    for (int cyc = 1; cyc <= 16 * (div + 1) + 4; cyc++) begin
      @(posedge HCLK); #1;
      if (spi_irq === 1'b1) irqs++;
      if (prev && !SPI_CLK) begin
        if (nrise > 0) begin
          vectors++;
          if (highrun != div + 1) begin
            miscompares++;
            $display("FAIL %s high_phase: got %0d cycles want %0d", tag, highrun, div + 1);
          end
        end
        vectors++;
        if (mosi_q.size() == 0) begin
          miscompares++;
          $display("FAIL %s mosi_extra_bit: got extra SPI_CLK fall, want none", tag);
        end else begin
          b = mosi_q.pop_front();
          if (SPI_MOSI !== b) begin
            miscompares++;
            $display("FAIL %s mosi_bit%0d: got %b want %b", tag, nrise, SPI_MOSI, b);
          end
        end
        lowrun = 0;
      end
      if (!prev && SPI_CLK) begin
        vectors++;
        if (lowrun != div + 1) begin
          miscompares++;
          $display("FAIL %s low_phase: got %0d cycles want %0d", tag, lowrun, div + 1);
        end
        nrise++;
        last_rise = cyc;
        highrun = 0;
      end
      if (!SPI_CLK) lowrun++; else highrun++;
      prev = SPI_CLK;
    end
    vectors++;
    if (nrise != DATA_W) begin
      miscompares++;
      $display("FAIL %s rise_count: got %0d want %0d", tag, nrise, DATA_W);
    end
    vectors++;
    if (last_rise != 15 * (div + 1) + 1) begin
      miscompares++;
      $display("FAIL %s last_rise_cycle: got %0d want %0d", tag, last_rise, 15 * (div + 1) + 1);
    end
    vectors++;
    if (irqs != exp_irq) begin
      miscompares++;
      $display("FAIL %s irq_pulses: got %0d want %0d", tag, irqs, exp_irq);
    end
    vectors++;
    if (SPI_CLK !== 1'b1) begin
      miscompares++;
      $display("FAIL %s clk_idle: got %b want 1", tag, SPI_CLK);
    end
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] rd;
    logic [7:0]  exp;
    ahb_read(A_DATA, rd);
    vectors++;
    if (rx_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s rx_underflow: got read %h with no expected byte", tag, rd);
    end else begin
      exp = rx_q.pop_front();
      if (rd !== {24'h0, exp}) begin
        miscompares++;
        $display("FAIL %s rx_data: got %h want %h", tag, rd, {24'h0, exp});
      end
    end
  endtask

  task automatic test_reset_values();
    logic [31:0] rd;
    vectors++;
    if ({SPI_CS, SPI_CLK, SPI_MOSI, spi_irq, HREADYOUT, HRESP} !== 6'b110010) begin
      miscompares++;
      $display("FAIL por_pins: got %b want 110010",
               {SPI_CS, SPI_CLK, SPI_MOSI, spi_irq, HREADYOUT, HRESP});
    end
    ahb_read(A_CTRL, rd);
    vectors++;
    if (rd !== 32'h1) begin miscompares++; $display("FAIL por_ctrl: got %h want %h", rd, 32'h1); end
    ahb_read(A_DIV, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL por_div: got %h want %h", rd, 32'h0); end
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL por_stat: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_div0_loopback();
    logic [31:0] rd;
    loop_en = 1'b1;
    ahb_write(A_DIV, 32'h0);
    start_xfer(8'hA5, 8'hA5, 1'b1);
    spi_watch(0, 0, "div0");
    vectors++;
    if (SPI_MOSI !== 1'b1) begin
      miscompares++;
      $display("FAIL div0 mosi_hold: got %b want 1", SPI_MOSI);
    end
    check_rx("div0");
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL div0_stat: got %h want %h", rd, 32'h2); end
  endtask

  task automatic test_div3_miso_high();
    logic [31:0] rd;
    loop_en = 1'b0;
    miso_lvl = 1'b1;
    ahb_write(A_DIV, 32'h3);
    start_xfer(8'h00, 8'hFF, 1'b1);
    spi_watch(3, 0, "div3");
    check_rx("div3");
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL div3_stat: got %h want %h", rd, 32'h2); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    loop_en = 1'b1;
    ahb_write(A_DIV, 32'h0);
    ahb_write(A_CTRL, 32'h2);
    start_xfer(8'h3C, 8'h3C, 1'b1);
    spi_watch(0, 1, "irq_on");
    vectors++;
    if (SPI_CS !== 1'b0) begin miscompares++; $display("FAIL irq_on cs: got %b want 0", SPI_CS); end
    check_rx("irq_on");
    ahb_write(A_CTRL, 32'h0);
    start_xfer(8'hC3, 8'hC3, 1'b1);
    spi_watch(0, 0, "irq_off");
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL irq_off_stat: got %h want %h", rd, 32'h2); end
    check_rx("irq_off");
  endtask

  task automatic test_busy_ignore();
    logic [31:0] rd;
    loop_en = 1'b1;
    ahb_write(A_DIV, 32'h1);
    start_xfer(8'h96, 8'h96, 1'b1);
    fork
      spi_watch(1, 0, "busy");
      begin
        repeat (2) @(posedge HCLK);
        ahb_write(A_DATA, 32'h3C);
        ahb_write(A_DIV, 32'h7);
        ahb_read(A_STAT, rd);
        vectors++;
        if (rd[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_flag: got %b want 1", rd[0]);
        end
      end
    join
    ahb_read(A_DIV, rd);
    vectors++;
    if (rd !== 32'h1) begin miscompares++; $display("FAIL busy_div_kept: got %h want %h", rd, 32'h1); end
    check_rx("busy");
  endtask

  task automatic test_done_race();
    logic [31:0] rd;
    loop_en = 1'b1;
    ahb_write(A_DIV, 32'h0);
    start_xfer(8'h5A, 8'h5A, 1'b0);
    // Lands the W1C data phase on the final HIGH cycle, the same edge done sets.
    repeat (14) begin @(posedge HCLK); #1; end
    ahb_write(A_STAT, 32'h2);
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h2) begin miscompares++; $display("FAIL race_set_wins: got %h want %h", rd, 32'h2); end
    ahb_write(A_STAT, 32'h2);
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL race_w1c: got %h want %h", rd, 32'h0); end
    check_rx("race");
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    loop_en = 1'b1;
    ahb_write(A_CTRL, 32'h0);
    ahb_write(A_DIV, 32'h3);
    ahb_write(A_DATA, 32'hFF);
    repeat (2) begin @(posedge HCLK); #1; end
    #2;
    HRESETn = 1'b0;
    #1;
    vectors++;
    if ({SPI_CS, SPI_CLK, SPI_MOSI, spi_irq} !== 4'b1100) begin
      miscompares++;
      $display("FAIL midreset_pins: got %b want 1100", {SPI_CS, SPI_CLK, SPI_MOSI, spi_irq});
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    ahb_read(A_STAT, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL midreset_stat: got %h want %h", rd, 32'h0); end
    ahb_read(A_DATA, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL midreset_data: got %h want %h", rd, 32'h0); end
    ahb_read(A_DIV, rd);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL midreset_div: got %h want %h", rd, 32'h0); end
  endtask

  initial begin
    HRESETn  = 1'b0;
    HSEL     = 1'b0;
    HADDR    = 32'h0;
    HTRANS   = 2'b00;
    HSIZE    = 3'b010;
    HPROT    = 4'b0011;
    HWRITE   = 1'b0;
    HWDATA   = 32'h0;
    HREADY   = 1'b1;
    loop_en  = 1'b1;
    miso_lvl = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    test_reset_values();
    test_div0_loopback();
    test_div3_miso_high();
    test_irq();
    test_busy_ignore();
    test_done_race();
    test_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
